hilo_mult_ctrl: RTL and testbench

Sequencing controller that sits between the execute stage and the 32-cycle shift-add unsigned multiplier. It accepts MULT/MULTU/MTHI/MTLO/MFHI/MFLO requests, issues the one-cycle start pulse and operands to the multiplier, and waits out its fixed latency. It applies sign correction for MULT, owns the architectural HI/LO registers, and stalls the pipeline while a multiply is in flight.

---
 rtl/mips_muldiv_pkg.sv | 26 ++
 rtl/hilo_regs.sv | 38 +++
 rtl/hilo_mult_ctrl.sv | 134 +++++++++++++
 tb/tb_hilo_mult_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
// Shared constants for the HI/LO multiply sequencing logic: funct codes,
// controller state encoding and the default multiplier latency.
package mips_muldiv_pkg;

    localparam int MUL_LATENCY_DEFAULT = 33;

    localparam logic [5:0] FN_MFHI  = 6'd16;
    localparam logic [5:0] FN_MTHI  = 6'd17;
    localparam logic [5:0] FN_MFLO  = 6'd18;
    localparam logic [5:0] FN_MTLO  = 6'd19;
    localparam logic [5:0] FN_MULT  = 6'd24;
    localparam logic [5:0] FN_MULTU = 6'd25;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Instructions that touch HI/LO and therefore must wait for a running multiply.
    function automatic logic is_hilo_op(input logic [5:0] f);
        return (f == FN_MULT) || (f == FN_MULTU) || (f == FN_MFHI) ||
               (f == FN_MFLO) || (f == FN_MTHI)  || (f == FN_MTLO);
    endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair with product and MTHI/MTLO write ports
// and the MFHI/MFLO read mux.
module hilo_regs
    import mips_muldiv_pkg::*;
#(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           prod_we_i,
    input  logic [2*W-1:0] prod_i,
    input  logic           hi_we_i,
    input  logic           lo_we_i,
    input  logic [W-1:0]   wdata_i,
    input  logic [5:0]     funct_i,
    output logic [W-1:0]   rdata_o
);

    logic [W-1:0] hi_q;
    logic [W-1:0] lo_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (prod_we_i) begin
            hi_q <= prod_i[2*W-1:W];
            lo_q <= prod_i[W-1:0];
        end else begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
        end
    end

    // Anything other than MFHI reads LO.
    assign rdata_o = (funct_i == FN_MFHI) ? hi_q : lo_q;

endmodule

// File: rtl/hilo_mult_ctrl.sv
// Sequencing controller for the 32-cycle shift-add multiplier: issues the
// start pulse, waits out the latency, sign-corrects MULT and stalls HI/LO users.
module hilo_mult_ctrl
    import mips_muldiv_pkg::*;
#(
    parameter int MUL_LATENCY = MUL_LATENCY_DEFAULT,
    parameter int W           = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           req_valid,
    input  logic [5:0]     funct,
    input  logic [W-1:0]   rs_data,
    input  logic [W-1:0]   rt_data,
    input  logic           flush,
    output logic           stall,
    output logic [W-1:0]   hilo_rdata,
    output logic           busy,
    output logic           mul_start,
    output logic [W-1:0]   mul_a,
    output logic [W-1:0]   mul_b,
    input  logic [2*W-1:0] mul_product
);

    localparam int CW = $clog2(MUL_LATENCY + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(MUL_LATENCY);

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          neg_q;
    logic          busy_q;
    logic          start_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;

    logic          accept;
    logic          is_mult;
    logic          is_multu;
    logic          mul_accept;
    logic [W-1:0]  abs_a;
    logic [W-1:0]  abs_b;
    logic          prod_we;
    logic [2*W-1:0] prod_val;
    logic          hi_we;
    logic          lo_we;

    assign stall      = req_valid & busy_q & is_hilo_op(funct);
    assign accept     = req_valid & ~stall;
    assign is_mult    = (funct == FN_MULT);
    assign is_multu   = (funct == FN_MULTU);
    assign mul_accept = accept & (is_mult | is_multu) & (state_q == ST_IDLE);

    // The multiplier is unsigned; -2^(W-1) negates to itself, which is the right magnitude.
    assign abs_a = rs_data[W-1] ? -rs_data : rs_data;
    assign abs_b = rt_data[W-1] ? -rt_data : rt_data;

    // A flush on the final RUN edge beats the result write.
    assign prod_we  = (state_q == ST_RUN) & (cnt_q == LAST_CNT) & ~flush;
    assign prod_val = neg_q ? -mul_product : mul_product;
    assign hi_we    = accept & (funct == FN_MTHI) & (state_q == ST_IDLE);
    assign lo_we    = accept & (funct == FN_MTLO) & (state_q == ST_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
            busy_q  <= 1'b0;
            start_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    start_q <= 1'b0;
                    if (mul_accept) begin
                        state_q <= ST_ISSUE;
                        busy_q  <= 1'b1;
                        start_q <= 1'b1;
                        a_q     <= is_mult ? abs_a : rs_data;
                        b_q     <= is_mult ? abs_b : rt_data;
                        neg_q   <= is_mult & (rs_data[W-1] ^ rt_data[W-1]);
                    end
                end
                ST_ISSUE: begin
                    start_q <= 1'b0;
                    if (flush) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q <= ST_RUN;
                        cnt_q   <= CW'(1);
                    end
                end
                ST_RUN: begin
                    start_q <= 1'b0;
                    if (flush || (cnt_q == LAST_CNT)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    start_q <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign mul_start = start_q;
    assign mul_a     = a_q;
    assign mul_b     = b_q;

    hilo_regs #(
        .W(W)
    ) u_hilo_regs (
        .clk       (clk),
        .rst_n     (reset),
        .prod_we_i (prod_we),
        .prod_i    (prod_val),
        .hi_we_i   (hi_we),
        .lo_we_i   (lo_we),
        .wdata_i   (rs_data),
        .funct_i   (funct),
        .rdata_o   (hilo_rdata)
    );

endmodule

// File: tb/tb_hilo_mult_ctrl.sv
// Directed bench for hilo_mult_ctrl with a latency-accurate model of the
// shift-add multiplier that only presents a valid product after E32.
module tb_hilo_mult_ctrl;
    import mips_muldiv_pkg::*;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           req_valid;
    logic [5:0]     funct;
    logic [W-1:0]   rs_data;
    logic [W-1:0]   rt_data;
    logic           flush;
    logic           stall;
    logic [W-1:0]   hilo_rdata;
    logic           busy;
    logic           mul_start;
    logic [W-1:0]   mul_a;
    logic [W-1:0]   mul_b;
    logic [2*W-1:0] mul_product;

    int total = 0;
    int bad = 0;
    int startCount = 0;

    logic [W-1:0] modelA = '0;
    logic [W-1:0] modelB = '0;
    int           modelCnt = 100;

    always #5 clk = ~clk;

    hilo_mult_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .funct       (funct),
        .rs_data     (rs_data),
        .rt_data     (rt_data),
        .flush       (flush),
        .stall       (stall),
        .hilo_rdata  (hilo_rdata),
        .busy        (busy),
        .mul_start   (mul_start),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_product (mul_product)
    );

    // Multiplier stand-in: samples operands at E0, product is garbage until after E32.
    always @(posedge clk) begin
        if (mul_start) begin
            modelA   <= mul_a;
            modelB   <= mul_b;
            modelCnt <= 0;
        end else if (modelCnt < 100) begin
            modelCnt <= modelCnt + 1;
        end
    end

    assign mul_product = (modelCnt >= 32) ? ({32'b0, modelA} * {32'b0, modelB})
                                          : 64'hA5A5_5A5A_C3C3_3C3C;

    always @(posedge clk) begin
        if (mul_start) startCount++;
    end

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [5:0] f,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid = v;
        funct     = f;
        rs_data   = a;
        rt_data   = b;
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic readHiLo(input string tag, input logic [W-1:0] expHi, input logic [W-1:0] expLo);
        applyStimulus(1'b1, FN_MFHI, '0, '0);
        #1;
        checkOutput({tag, "_hi"}, hilo_rdata, expHi);
        applyStimulus(1'b1, FN_MFLO, '0, '0);
        #1;
        checkOutput({tag, "_lo"}, hilo_rdata, expLo);
        applyStimulus(1'b0, 6'd0, '0, '0);
    endtask

    task automatic runMul(input string tag, input logic [5:0] f,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] expA, input logic [W-1:0] expB,
                          input logic [W-1:0] expHi, input logic [W-1:0] expLo);
        int s0;
        int cyc;
        s0 = startCount;
        applyStimulus(1'b1, f, a, b);
        step();
        checkOutput({tag, "_start"}, mul_start, 1'b1);
        checkOutput({tag, "_busy"}, busy, 1'b1);
        checkOutput({tag, "_a"}, mul_a, expA);
        checkOutput({tag, "_b"}, mul_b, expB);
        applyStimulus(1'b0, 6'd0, '0, '0);
        cyc = 1;
        for (int i = 0; i < 60; i++) begin
            step();
            if (i == 0) checkOutput({tag, "_start_off"}, mul_start, 1'b0);
            if (!busy) break;
            cyc++;
        end
        checkOutput({tag, "_busy_cycles"}, cyc, 34);
        checkOutput({tag, "_pulses"}, startCount - s0, 1);
        readHiLo(tag, expHi, expLo);
    endtask

    initial begin
        int n;
        applyStimulus(1'b0, 6'd0, '0, '0);
        flush = 1'b0;
        repeat (3) step();
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_start", mul_start, 1'b0);
        checkOutput("rst_a", mul_a, 32'h0);
        checkOutput("rst_b", mul_b, 32'h0);
        reset = 1'b1;
        step();

        applyStimulus(1'b1, FN_MFHI, '0, '0);
        #1;
        checkOutput("idle_mfhi", hilo_rdata, 32'h0);
        checkOutput("idle_stall", stall, 1'b0);
        step();
        applyStimulus(1'b1, FN_MFLO, '0, '0);
        #1;
        checkOutput("idle_mflo", hilo_rdata, 32'h0);
        step();
        applyStimulus(1'b0, 6'd0, '0, '0);
        step();
        checkOutput("idle_no_start", startCount, 0);

        runMul("multu_ff", FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        runMul("mult_m1x2", FN_MULT, 32'hFFFF_FFFF, 32'h0000_0002,
               32'h0000_0001, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        runMul("mult_min", FN_MULT, 32'h8000_0000, 32'h8000_0000,
               32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);

        // MFLO presented right behind a MULTU waits for the whole busy window.
        applyStimulus(1'b1, FN_MULTU, 32'd3, 32'd5);
        step();
        applyStimulus(1'b1, FN_MFLO, '0, '0);
        #1;
        n = 0;
        for (int i = 0; i < 60; i++) begin
            if (!stall) break;
            n++;
            step();
        end
        checkOutput("mflo_stall_cycles", n, 34);
        checkOutput("mflo_busy_low", busy, 1'b0);
        checkOutput("mflo_value", hilo_rdata, 32'd15);
        step();
        applyStimulus(1'b0, 6'd0, '0, '0);

        // Unrelated funct flows while busy; MTHI waits and HI holds until accept.
        applyStimulus(1'b1, FN_MULTU, 32'h0001_0000, 32'h0003_0000);
        step();
        applyStimulus(1'b1, 6'd32, 32'h1, 32'h2);
        repeat (5) step();
        checkOutput("add_no_stall", stall, 1'b0);
        checkOutput("add_busy", busy, 1'b1);
        applyStimulus(1'b1, FN_MTHI, 32'h0000_1234, '0);
        #1;
        checkOutput("mthi_stall", stall, 1'b1);
        step();
        step();
        checkOutput("mthi_stall_held", stall, 1'b1);
        applyStimulus(1'b1, FN_MFHI, '0, '0);
        #1;
        checkOutput("mthi_hi_unchanged", hilo_rdata, 32'h0);
        applyStimulus(1'b1, FN_MTHI, 32'h0000_1234, '0);
        for (int i = 0; i < 60; i++) begin
            #1;
            if (!stall) break;
            step();
        end
        checkOutput("mthi_release", stall, 1'b0);
        applyStimulus(1'b1, FN_MFHI, '0, '0);
        #1;
        checkOutput("mul_hi_written", hilo_rdata, 32'h3);
        applyStimulus(1'b1, FN_MTHI, 32'h0000_1234, '0);
        step();
        readHiLo("mthi_done", 32'h0000_1234, 32'h0);

        // Flush mid-run: result discarded.
        applyStimulus(1'b1, FN_MULTU, 32'd7, 32'd9);
        step();
        applyStimulus(1'b0, 6'd0, '0, '0);
        repeat (9) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("flush_busy", busy, 1'b0);
        repeat (40) step();
        readHiLo("flush_keep", 32'h0000_1234, 32'h0);

        // Flush on the final RUN edge wins over the write.
        applyStimulus(1'b1, FN_MULTU, 32'd2, 32'd3);
        step();
        applyStimulus(1'b0, 6'd0, '0, '0);
        repeat (33) step();
        checkOutput("lastflush_busy_before", busy, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        checkOutput("lastflush_busy_after", busy, 1'b0);
        readHiLo("lastflush_keep", 32'h0000_1234, 32'h0);

        // Asynchronous reset mid-multiply.
        applyStimulus(1'b1, FN_MULTU, 32'd7, 32'd9);
        step();
        applyStimulus(1'b0, 6'd0, '0, '0);
        repeat (19) step();
        applyStimulus(1'b1, FN_MFHI, '0, '0);
        reset = 1'b0;
        #1;
        checkOutput("arst_busy", busy, 1'b0);
        checkOutput("arst_start", mul_start, 1'b0);
        checkOutput("arst_a", mul_a, 32'h0);
        checkOutput("arst_b", mul_b, 32'h0);
        checkOutput("arst_stall", stall, 1'b0);
        checkOutput("arst_hi", hilo_rdata, 32'h0);
        applyStimulus(1'b1, FN_MFLO, '0, '0);
        #1;
        checkOutput("arst_lo", hilo_rdata, 32'h0);
        step();
        reset = 1'b1;
        applyStimulus(1'b0, 6'd0, '0, '0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

endmodule
